rca_batch_accumulator: RTL

Sequential accumulator that sits directly downstream of the 64-bit ripple-carry adder. It instantiates `RCA_64bit` with operand `b` tied to its own accumulator register and registers the adder's `sum`/`c_out` each time an operand is accepted. After `BATCH` operands it presents the 64-bit total and the number of carry-outs through a valid/ready output handshake, then clears itself for the next batch.

---
 rtl/rca_batch_accumulator.sv | 109 ++++++++++
 1 files changed

// File: rtl/rca_batch_accumulator.sv
// Batch accumulator built around a 64-bit ripple-carry adder: sums BATCH operands,
// counts adder carry-outs (saturating), and hands the total downstream via valid/ready.

module RCA_64bit (
  input  logic [63:0] a,
  input  logic [63:0] b,
  input  logic        c_in,
  output logic [63:0] sum,
  output logic        c_out
);

  logic carry;

  // Explicit bit-serial carry chain; a single variable avoids a looping net vector.
  always_comb begin
    sum   = '0;
    carry = c_in;
    for (int i = 0; i < 64; i++) begin
      sum[i] = a[i] ^ b[i] ^ carry;
      carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
    end
    c_out = carry;
  end

endmodule

module rca_batch_accumulator #(
  parameter int BATCH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [63:0]      in_data,
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [63:0]      out_sum,
  output logic [CNT_W-1:0] out_carries,
  output logic             dbg_state
);

  typedef enum logic {
    ACC  = 1'b0,
    DONE = 1'b1
  } state_t;

  localparam logic [7:0] LAST_IDX = 8'(BATCH - 1);

  state_t           state;
  state_t           state_nxt;
  logic [63:0]      acc;
  logic [CNT_W-1:0] carries;
  logic [7:0]       idx;
  logic [63:0]      rca_sum;
  logic             rca_cout;
  logic             accept;
  logic             handshake;

  RCA_64bit u_rca (
    .a    (in_data),
    .b    (acc),
    .c_in (in_cin),
    .sum  (rca_sum),
    .c_out(rca_cout)
  );

  // Handshakes: a transfer happens on a rising edge where valid and ready are both
  // high. in_ready depends only on state and rst_n; out_valid only on state.
  assign in_ready    = (state == ACC) && rst_n;
  assign out_valid   = (state == DONE);
  assign accept      = in_valid && in_ready;
  assign handshake   = out_valid && out_ready;
  assign out_sum     = acc;
  assign out_carries = carries;
  assign dbg_state   = state;

  always_comb begin
    state_nxt = state;
    case (state)
      ACC:     if (accept && (idx == LAST_IDX)) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = ACC;
      default: state_nxt = ACC;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ACC;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc     <= '0;
      carries <= '0;
      idx     <= '0;
    end else if (accept) begin
      acc <= rca_sum;
      // The bit-63 carry is only counted, never folded back into acc.
      if (rca_cout && (carries != {CNT_W{1'b1}})) carries <= carries + CNT_W'(1);
      idx <= (idx == LAST_IDX) ? 8'd0 : idx + 8'd1;
    end else if (handshake) begin
      acc     <= '0;
      carries <= '0;
    end
  end

endmodule
